// File: rtl/serial_adder_sub_if.sv
// serial_adder_sub_if: start/busy/done handshake and operand/result bus of the serial adder
interface serial_adder_sub_if #(parameter int WIDTH = 8);
  logic start;
  logic cin;
  logic sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic cout;
  logic ovf;
  logic [WIDTH-1:0] sum;
  modport master (output start, cin, sub, a, b, input busy, done, cout, ovf, sum);
  modport slave (input start, cin, sub, a, b, output busy, done, cout, ovf, sum);
endinterface

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: LSB-first multi-cycle add/subtract, BITS_PER_CYCLE full-adder cells per cycle
module serial_adder_sub #(
  parameter int WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  serial_adder_sub_if.slave bus
);
  localparam int K = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / K;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, part, part_n;
  logic c_r, cy, c_msb, accept, last;
  logic [K-1:0] s;
  assign accept = bus.start && state != RUN;
  assign last = cnt == CW'(STEPS - 1);
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  // c_msb ends up as the carry into the top cell, which on the last step is bit WIDTH-1
  always_comb begin
    cy = c_r;
    c_msb = c_r;
    s = '0;
    for (int i = 0; i < K; i++) begin
      c_msb = cy;
      s[i] = a_r[i] ^ b_r[i] ^ cy;
      cy = (a_r[i] & b_r[i]) | (cy & (a_r[i] ^ b_r[i]));
    end
    part_n = WIDTH'({s, part} >> K);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      part <= '0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      cnt <= '0;
      a_r <= bus.a;
      b_r <= bus.sub ? ~bus.b : bus.b;
      c_r <= bus.sub ^ bus.cin;
    end else if (state == RUN) begin
      a_r <= a_r >> K;
      b_r <= b_r >> K;
      c_r <= cy;
      part <= part_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        bus.sum <= part_n;
        bus.cout <= cy;
        bus.ovf <= c_msb ^ cy;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
